// File: rtl/seq_bin2bcd_ctrl.sv
// seq_bin2bcd_ctrl: multi-cycle binary-to-BCD converter using shift-and-add-3.
// Each input bit takes one ADJUST cycle and one SHIFT cycle. The result and
// the overflow flag are registered and appear together with a one-cycle done
// pulse. Inputs larger than 10^DIGITS-1 skip the datapath and report all ones
// with err set.
module seq_bin2bcd_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      binary,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done,
  output logic                  busy,
  output logic                  err
);

  // Scratch register: BCD digits on top, binary operand underneath.
  localparam int SW = 4 * DIGITS + WIDTH;
  // The bit counter must be able to hold WIDTH itself.
  localparam int CW = $clog2(WIDTH + 1);

  // Largest value representable in DIGITS decimal digits. Evaluated at
  // elaboration; 64 bits covers DIGITS up to 10.
  function automatic logic [63:0] max_value(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

  localparam logic [63:0]   MAX_VAL  = max_value(DIGITS);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADJUST = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       scratch_q, scratch_d;
  logic [SW-1:0]       scratch_adj;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  // The binary part of the scratch register passes through the adjust step
  // untouched; only the digit nibbles are corrected.
  assign scratch_adj[WIDTH-1:0] = scratch_q[WIDTH-1:0];

  // Every digit that is 5 or more gets +3 so the following shift carries
  // correctly into the next decimal digit. Digits never exceed 9 while the
  // input is in range, so the 4-bit sum never wraps.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    logic [3:0] nib;
    assign nib = scratch_q[WIDTH + 4*gi +: 4];
    assign scratch_adj[WIDTH + 4*gi +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
  end

  // Next-state and next-output logic for the conversion sequencer.
  always_comb begin
    state_d   = state_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    bcd_d     = bcd_q;
    err_d     = err_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (64'(binary) > MAX_VAL) begin
            // Overflow: no shifting. The counter is reused to spend one
            // extra cycle in DONE so the error result appears on the edge
            // after the one that latched the request.
            ovf_d   = 1'b1;
            cnt_d   = CNT_ONE;
            state_d = DONE;
          end else begin
            ovf_d     = 1'b0;
            scratch_d = SW'(binary);
            cnt_d     = CNT_LOAD;
            state_d   = ADJUST;
          end
        end
      end

      ADJUST: begin
        scratch_d = scratch_adj;
        state_d   = SHIFT;
      end

      SHIFT: begin
        // Bits leaving the top digit are dropped; that only happens for
        // inputs that were already rejected as overflow.
        scratch_d = {scratch_q[SW-2:0], 1'b0};
        cnt_d     = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          // Last bit shifted: publish the digits on the edge entering DONE.
          state_d = DONE;
          done_d  = 1'b1;
          bcd_d   = scratch_d[SW-1 -: 4*DIGITS];
          err_d   = 1'b0;
        end else begin
          state_d = ADJUST;
        end
      end

      DONE: begin
        if (ovf_q && (cnt_q != '0)) begin
          // First overflow cycle: publish the error encoding and stay.
          cnt_d  = cnt_q - CNT_ONE;
          done_d = 1'b1;
          bcd_d  = '1;
          err_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      scratch_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      bcd_q     <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      bcd_q     <= bcd_d;
      err_q     <= err_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bcd  = bcd_q;
  assign err  = err_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule
